// File: rtl/seg7_scan_decoder.sv
// Watches a multiplexed 7-segment bus and reconstructs the BCD digit shown on each position.
// Captures a digit once per stable period and pulses frame when every position has been refreshed.
module seg7_scan_decoder #(
    parameter int unsigned NDIG   = 4,
    parameter int unsigned STABLE = 4,
    parameter int unsigned CW     = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [0:6]        seg,
    input  logic [NDIG-1:0]   an,
    output logic [4*NDIG-1:0] bcd,
    output logic [NDIG-1:0]   err,
    output logic              frame
);

    localparam int unsigned SW = NDIG + 7;
    localparam int unsigned BW = 4 * NDIG;

    logic [SW-1:0]   samp_q, samp_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            captured_q, captured_d;
    logic [NDIG-1:0] seen_q, seen_d;
    logic [BW-1:0]   bcd_q, bcd_d;
    logic [NDIG-1:0] err_q, err_d;
    logic            frame_q, frame_d;

    logic [NDIG-1:0] held_an;
    logic [6:0]      held_seg;
    logic            change;
    logic            onehot;
    logic            cap;
    logic [4:0]      dec;

    // Pattern abcdefg (a in bit 6) -> {invalid, digit}; invalid patterns read back as 4'hF.
    function automatic logic [4:0] decode(input logic [6:0] p);
        case (p)
            7'b1111110: return 5'h00;
            7'b0110000: return 5'h01;
            7'b1101101: return 5'h02;
            7'b1111001: return 5'h03;
            7'b0110011: return 5'h04;
            7'b1011011: return 5'h05;
            7'b1011111: return 5'h06;
            7'b1110000: return 5'h07;
            7'b1111111: return 5'h08;
            7'b1111011: return 5'h09;
            default:    return 5'h1F;
        endcase
    endfunction

    assign held_an  = samp_q[SW-1:7];
    assign held_seg = samp_q[6:0];
    assign onehot   = (held_an != '0) && ((held_an & (held_an - NDIG'(1))) == '0);
    assign dec      = decode(held_seg);

    // Stability tracking, single capture per stable period, frame bookkeeping.
    always_comb begin
        samp_d     = {an, seg};
        change     = (samp_d != samp_q);
        cnt_d      = cnt_q;
        captured_d = captured_q;
        seen_d     = seen_q;
        bcd_d      = bcd_q;
        err_d      = err_q;
        frame_d    = 1'b0;
        cap        = 1'b0;

        if (change) begin
            cnt_d      = '0;
            captured_d = 1'b0;
        end else begin
            if (cnt_q != CW'(STABLE - 1)) begin
                cnt_d = cnt_q + CW'(1);
            end
            cap = (cnt_d == CW'(STABLE - 1)) && onehot && !captured_q;
        end

        if (cap) begin
            captured_d = 1'b1;
            for (int unsigned i = 0; i < NDIG; i++) begin
                if (held_an[i]) begin
                    bcd_d[4*i +: 4] = dec[3:0];
                    err_d[i]        = dec[4];
                end
            end
            seen_d = seen_q | held_an;
            // The capture completing the frame does not carry into the next one.
            if (&seen_d) begin
                frame_d = 1'b1;
                seen_d  = '0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            samp_q     <= '0;
            cnt_q      <= '0;
            captured_q <= 1'b0;
            seen_q     <= '0;
            bcd_q      <= '0;
            err_q      <= '0;
            frame_q    <= 1'b0;
        end else begin
            samp_q     <= samp_d;
            cnt_q      <= cnt_d;
            captured_q <= captured_d;
            seen_q     <= seen_d;
            bcd_q      <= bcd_d;
            err_q      <= err_d;
            frame_q    <= frame_d;
        end
    end

    assign bcd   = bcd_q;
    assign err   = err_q;
    assign frame = frame_q;

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Scoreboard bench for seg7_scan_decoder: a run-length reference model predicts bcd/err/frame
// for every clock; a monitor compares the DUT against the queued predictions.
module tb_seg7_scan_decoder;

    localparam int NDIG   = 4;
    localparam int STABLE = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [0:6]  seg = '0;
    logic [3:0]  an = '0;
    logic [15:0] bcd;
    logic [3:0]  err;
    logic        frame;

    seg7_scan_decoder #(.NDIG(NDIG), .STABLE(STABLE), .CW(3)) dut (
        .clk(clk), .reset(reset), .seg(seg), .an(an),
        .bcd(bcd), .err(err), .frame(frame)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] bcd;
        logic [3:0]  err;
        logic        frame;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   dut_frames = 0;

    logic [6:0] pats[10];

    // Reference model: last applied value, how many consecutive edges it has been sampled
    logic [10:0] m_prev;
    int          m_run;
    logic [15:0] m_bcd;
    logic [3:0]  m_err;
    logic [3:0]  m_seen;
    logic        m_frame;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Predict the DUT state after the coming rising edge.
    task automatic model_step();
        logic [10:0] v;
        logic [6:0]  s;
        int          pos;
        int          digit;
        if (reset) begin
            m_prev = '0; m_run = 1; m_bcd = '0; m_err = '0; m_seen = '0; m_frame = 1'b0;
            return;
        end
        s = seg;
        v = {an, s};
        if (v == m_prev) begin
            if (m_run < 1000) m_run++;
        end else begin
            m_run = 1;
        end
        m_prev  = v;
        m_frame = 1'b0;
        if (m_run == STABLE && $countones(an) == 1) begin
            pos = 0;
            for (int k = 0; k < NDIG; k++) if (an[k]) pos = k;
            digit = -1;
            for (int k = 0; k < 10; k++) if (pats[k] == s) digit = k;
            if (digit >= 0) begin
                m_bcd[4*pos +: 4] = 4'(digit);
                m_err[pos] = 1'b0;
            end else begin
                m_bcd[4*pos +: 4] = 4'hF;
                m_err[pos] = 1'b1;
            end
            m_seen[pos] = 1'b1;
            if (m_seen == 4'hF) begin
                m_frame = 1'b1;
                m_seen  = '0;
            end
        end
    endtask

    task automatic push_exp();
        exp_t e;
        e.bcd = m_bcd; e.err = m_err; e.frame = m_frame;
        exp_q.push_back(e);
    endtask

    // Called at a falling edge; returns at the falling edge after the last sampled cycle.
    task automatic hold(input logic [3:0] a, input logic [6:0] s, input int n);
        for (int c = 0; c < n; c++) begin
            an  = a;
            seg = s;
            model_step();
            push_exp();
            @(negedge clk);
        end
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        an    = 4'($urandom);
        seg   = 7'($urandom);
        #1;
        chk("reset_bcd", 32'(bcd), 32'h0);
        chk("reset_err", 32'(err), 32'h0);
        chk("reset_frame", 32'(frame), 32'h0);
        for (int c = 0; c < n; c++) begin
            model_step();
            push_exp();
            @(negedge clk);
        end
        reset = 1'b0;
    endtask

    // Monitor: compare the DUT against the prediction for each rising edge.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (frame === 1'b1) dut_frames++;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("cycle_bcd_err_frame", 32'({bcd, err, frame}), 32'({e.bcd, e.err, e.frame}));
        end
    end

    initial begin
        int f0;
        logic [3:0] a;
        logic [6:0] s;
        pats = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011,
                 7'b1011011, 7'b1011111, 7'b1110000, 7'b1111111, 7'b1111011};
        m_prev = '0; m_run = 1; m_bcd = '0; m_err = '0; m_seen = '0; m_frame = 1'b0;

        @(negedge clk);
        do_reset(2);

        // Full scan, twice
        f0 = dut_frames;
        for (int r = 0; r < 2; r++) begin
            hold(4'b0001, 7'b1111001, 6);
            hold(4'b0010, 7'b1111110, 6);
            hold(4'b0100, 7'b1101101, 6);
            hold(4'b1000, 7'b1011011, 6);
            chk("scan_bcd", 32'(bcd), 32'h5203);
            chk("scan_err", 32'(err), 32'h0);
        end
        chk("scan_frames", 32'(dut_frames - f0), 32'd2);

        // Short hold does not capture, full hold captures
        hold(4'b0001, 7'b0110000, 3);
        chk("short_hold_bcd", 32'(bcd), 32'h5203);
        hold(4'b0000, 7'b0000000, 1);
        hold(4'b0001, 7'b0110000, 3);
        chk("pre_capture_bcd", 32'(bcd), 32'h5203);
        hold(4'b0001, 7'b0110000, 1);
        chk("full_hold_bcd", 32'(bcd), 32'h5201);
        hold(4'b0001, 7'b0110000, 5);

        // Invalid pattern then valid recapture
        hold(4'b0100, 7'b0000001, 5);
        chk("invalid_bcd", 32'(bcd), 32'h5F01);
        chk("invalid_err", 32'(err), 32'h4);
        hold(4'b0100, 7'b1110000, 5);
        chk("recapture_bcd", 32'(bcd), 32'h5701);
        chk("recapture_err", 32'(err), 32'h0);

        // Blanking and multi-hot select
        f0 = dut_frames;
        hold(4'b0000, 7'b1111111, 10);
        hold(4'b0011, 7'b1111111, 10);
        chk("blank_bcd", 32'(bcd), 32'h5701);
        chk("blank_err", 32'(err), 32'h0);
        chk("blank_frames", 32'(dut_frames - f0), 32'd0);

        // Reset discards a partial frame
        f0 = dut_frames;
        hold(4'b0001, 7'b1111111, 5);
        hold(4'b0010, 7'b0110011, 5);
        do_reset(1);
        hold(4'b0100, 7'b1011111, 5);
        hold(4'b1000, 7'b1111011, 5);
        chk("partial_frames", 32'(dut_frames - f0), 32'd0);
        hold(4'b0001, 7'b1111111, 5);
        hold(4'b0010, 7'b0110011, 5);
        chk("refill_frames", 32'(dut_frames - f0), 32'd1);
        chk("refill_bcd", 32'(bcd), 32'h9648);

        // Randomised scanning with occasional resets
        for (int t = 0; t < 250; t++) begin
            int kind;
            kind = int'($urandom_range(0, 9));
            if (kind < 7)       a = 4'(1 << $urandom_range(0, 3));
            else if (kind == 7) a = 4'b0000;
            else                a = 4'($urandom);
            if ($urandom_range(0, 9) < 7) s = pats[$urandom_range(0, 9)];
            else                          s = 7'($urandom);
            hold(a, s, int'($urandom_range(1, 7)));
            if ($urandom_range(0, 39) == 0) do_reset(int'($urandom_range(1, 2)));
        end
        hold(4'b0000, 7'b0000000, 1);

        repeat (3) @(negedge clk);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/seg7_scan_decoder.md
Name: seg7_scan_decoder

Overview:
- Inverse of the bcd-7 display converter. Watches a time-multiplexed 7-segment display bus (segment lines plus one-hot digit select) and reconstructs the BCD digit shown on each position.
- Filters scan transitions and glitches with a stability counter and flags patterns that are not a decimal digit.
- Signals when a complete frame (every digit position refreshed) has been captured.
- Used as a display-bus monitor and as the checking end of display test benches.

Parameters:
NDIG, 4, number of multiplexed digit positions (>=1)
STABLE, 4, consecutive identical samples required before capture (>=2)
CW, 3, stability counter width; must satisfy 2^CW > STABLE

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
seg  input  [0:6]  segment lines, seg[0]=a ... seg[6]=g, active-high, same order as the bcd-7 converter output
an  input  NDIG  digit select, active-high, one-hot while a digit is driven; an[i] selects position i
bcd  output  4*NDIG  captured digits; position i at bcd[4*i+3:4*i]
err  output  NDIG  err[i]=1 if the last capture of position i was not a valid digit pattern
frame  output  1  one-cycle pulse: all NDIG positions captured since the previous frame or reset

Behaviour:
- Valid patterns (seg[0:6] = abcdefg), all others invalid:
  - 0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011
  - 5=1011011, 6=1011111, 7=1110000, 8=1111111, 9=1111011
- Sampling:
  - {an,seg} is registered every clock into a sample register.
  - The stability counter resets to 0 when the new sample differs from the held sample; otherwise it increments, saturating at STABLE-1.
- Capture condition: counter reaches STABLE-1, held an is exactly one-hot, and no capture has yet occurred for this stable period (internal captured flag, cleared on any sample change).
- Capture timing: if {an,seg} changes to a new value sampled at edge E0 and then stays constant, capture occurs at edge E0+STABLE-1. bcd/err are visible in the following cycle.
- Capture action for position i:
  - Valid pattern: bcd digit i <= decoded value, err[i] <= 0.
  - Invalid pattern: bcd digit i <= 4'hF, err[i] <= 1.
  - Other positions are unchanged.
- Exactly one capture per stable period; a value held for any length beyond STABLE captures once.
- an = 0 (blanking) or multi-hot: never captures; counter still runs.
- A hold shorter than STABLE samples: no capture, no state change apart from the counter.
- Frame tracking:
  - seen[NDIG-1:0] sets bit i on each capture of position i.
  - When a capture makes seen all-ones, frame=1 for exactly the next cycle, and seen is cleared at that same edge. That capture counts toward the completed frame only.
  - Recapturing an already-seen position before the frame completes updates bcd/err but does not advance seen.
- Reset (asynchronous, any time, including mid-frame):
  - bcd=0, err=0, frame=0, seen=0, counter=0, captured flag=0, sample register=0.
  - Partial frames are discarded.
- No combinational path from inputs to outputs. All outputs are registered.

Test Plan:
1. Assert reset mid-simulation with random inputs -> bcd=16'h0000, err=4'b0000, frame=0 immediately, without waiting for a clock edge.
2. NDIG=4, STABLE=4. Scan an=0001/seg=1111001, an=0010/1111110, an=0100/1101101, an=1000/1011011, each held 6 cycles -> after last capture bcd=16'h5203, err=0, frame high exactly one cycle; a second identical scan produces a second single frame pulse.
3. Hold an=0001/seg=0110000 for exactly 3 cycles, then 4 cycles -> no capture after the 3-cycle hold; bcd[3:0]=1 after the 4-cycle hold, captured at E0+3, and only once.
4. an=0100 with seg=0000001 (or 1110011) held 5 cycles -> bcd[11:8]=4'hF, err[2]=1. A later valid 7 on an=0100 -> bcd[11:8]=7, err[2]=0.
5. an=0000 and an=0011 with seg=1111111, each held 10 cycles -> bcd, err and seen unchanged; no frame pulse.
6. Capture positions 0 and 1, assert reset for 1 cycle, then capture positions 2 and 3 -> no frame pulse. Capturing 0 and 1 again -> frame pulses once.
